inv_round_key_gen: RTL and testbench

//  AES-128 decryption key sequencer. It expands a loaded cipher key forward to the round-10 key,

---
 rtl/aes_key_pkg.sv | 37 +++
 rtl/key_sub_word.sv | 30 +++
 rtl/sbox.sv | 34 +++
 rtl/inv_round_key_gen.sv | 172 +++++++++++++++++
 tb/tb_inv_round_key_gen.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_key_pkg
// Brief   : Shared AES-128 key-schedule constants, state type and rcon lookup.
// Rev     : 1.0  initial release
// ============================================================================
package aes_key_pkg;

    localparam int AES_NROUNDS = 10;
    localparam int AES_KEY_W   = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPAND  = 2'd1,
        READY   = 2'd2,
        DECRYPT = 2'd3
    } key_state_t;

    // Round constant for rounds 1..10; index 0 and out-of-range return 0.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_sub_word.sv
`default_nettype none
// ============================================================================
// Module : key_sub_word
// Brief  : RotWord + SubWord + rcon XOR on one 32-bit key-schedule word.
// Rev    : 1.0  initial release
// ============================================================================
module key_sub_word (
    input  logic [31:0] word_i,
    input  logic [7:0]  rcon_i,
    output logic [31:0] word_o
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign w_rot = {word_i[23:0], word_i[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            sbox u_sbox (
                .in_i  (w_rot[8*gi +: 8]),
                .out_o (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign word_o = w_sub ^ {rcon_i, 24'h000000};

endmodule
`default_nettype wire

// File: rtl/sbox.sv
`default_nettype none
// ============================================================================
// Module : sbox
// Brief  : AES forward S-box, purely combinational byte substitution.
// Rev    : 1.0  initial release
// ============================================================================
module sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:255][7:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = C_SBOX[in_i];

endmodule
`default_nettype wire

// File: rtl/inv_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module : inv_round_key_gen
// Brief  : AES-128 decrypt key sequencer: forward-expands to the round-10 key,
//          then steps the schedule back toward round 0 on request.
//          Build option INV_KEY_CACHE_EN stores all round keys in an array.
// Rev    : 1.0  initial release
// ============================================================================
module inv_round_key_gen
    import aes_key_pkg::*;
#(
    parameter int NROUNDS = AES_NROUNDS,
    parameter int KEY_W   = AES_KEY_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             chg_key,
    input  logic [KEY_W-1:0] rx_key,
    input  logic             dec_start,
    input  logic             dec_step,
    output logic [KEY_W-1:0] dec_key,
    output logic [3:0]       dec_round,
    output logic             key_ready,
    output logic             expand_busy,
    output logic             round_valid
);

    localparam logic [3:0] C_LAST = 4'(NROUNDS);

    key_state_t       state_q, state_d;
    logic [KEY_W-1:0] work_q, work_d;
    logic [KEY_W-1:0] dec_key_q, dec_key_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0]       dec_round_q, dec_round_d;
    logic             key_ready_q, key_ready_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [31:0]      w_sw_in;
    logic [31:0]      w_sw_out;
    logic [7:0]       w_rcon;
    logic [KEY_W-1:0] w_fwd;
    logic [KEY_W-1:0] w_r10;
    logic [KEY_W-1:0] w_prev;

    key_sub_word u_sub_word (
        .word_i (w_sw_in),
        .rcon_i (w_rcon),
        .word_o (w_sw_out)
    );

    assign w_fwd[127:96] = work_q[127:96] ^ w_sw_out;
    assign w_fwd[95:64]  = work_q[95:64]  ^ w_fwd[127:96];
    assign w_fwd[63:32]  = work_q[63:32]  ^ w_fwd[95:64];
    assign w_fwd[31:0]   = work_q[31:0]   ^ w_fwd[63:32];

`ifdef INV_KEY_CACHE_EN
    logic [KEY_W-1:0] cache_q [0:NROUNDS];

    assign w_sw_in = work_q[31:0];
    assign w_rcon  = rcon(rnd_q);
    assign w_r10   = cache_q[C_LAST];
    assign w_prev  = cache_q[dec_round_q - 4'd1];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i <= NROUNDS; i++) begin
                cache_q[i] <= '0;
            end
        end else if (chg_key) begin
            cache_q[0] <= rx_key;
        end else if (state_q == EXPAND) begin
            cache_q[rnd_q] <= w_fwd;
        end
    end
`else
    logic [KEY_W-1:0] r10_q;
    logic [31:0]      w_inv_w3;

    // The S-box path is shared: forward expansion in EXPAND, inverse round in DECRYPT.
    assign w_inv_w3 = dec_key_q[31:0] ^ dec_key_q[63:32];
    assign w_sw_in  = (state_q == DECRYPT) ? w_inv_w3 : work_q[31:0];
    assign w_rcon   = (state_q == DECRYPT) ? rcon(dec_round_q) : rcon(rnd_q);
    assign w_r10    = r10_q;
    assign w_prev   = {dec_key_q[127:96] ^ w_sw_out,
                       dec_key_q[95:64]  ^ dec_key_q[127:96],
                       dec_key_q[63:32]  ^ dec_key_q[95:64],
                       w_inv_w3};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r10_q <= '0;
        end else if (!chg_key && state_q == EXPAND && rnd_q == C_LAST) begin
            r10_q <= w_fwd;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dec_key_d   = dec_key_q;
        rnd_d       = rnd_q;
        dec_round_d = dec_round_q;
        key_ready_d = key_ready_q;
        busy_d      = busy_q;
        valid_d     = valid_q;

        if (chg_key) begin
            state_d     = EXPAND;
            work_d      = rx_key;
            rnd_d       = 4'd1;
            busy_d      = 1'b1;
            key_ready_d = 1'b0;
            valid_d     = 1'b0;
        end else begin
            case (state_q)
                EXPAND: begin
                    work_d = w_fwd;
                    rnd_d  = rnd_q + 4'd1;
                    if (rnd_q == C_LAST) begin
                        state_d     = READY;
                        busy_d      = 1'b0;
                        key_ready_d = 1'b1;
                    end
                end
                READY, DECRYPT: begin
                    if (dec_start) begin
                        state_d     = DECRYPT;
                        dec_key_d   = w_r10;
                        dec_round_d = C_LAST;
                        valid_d     = 1'b1;
                    end else if (state_q == DECRYPT && dec_step && dec_round_q != 4'd0) begin
                        dec_key_d   = w_prev;
                        dec_round_d = dec_round_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            dec_key_q   <= '0;
            rnd_q       <= 4'd0;
            dec_round_q <= 4'd0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dec_key_q   <= dec_key_d;
            rnd_q       <= rnd_d;
            dec_round_q <= dec_round_d;
            key_ready_q <= key_ready_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign dec_key     = dec_key_q;
    assign dec_round   = dec_round_q;
    assign key_ready   = key_ready_q;
    assign expand_busy = busy_q;
    assign round_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_inv_round_key_gen
// Brief  : Directed self-checking bench for inv_round_key_gen (scoreboard queue).
// Rev    : 1.0  initial release
// ============================================================================
module tb_inv_round_key_gen;

    localparam logic [127:0] C_KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        string        tag;
        logic [134:0] v;
    } exp_t;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         chg_key;
    logic [127:0] rx_key;
    logic         dec_start;
    logic         dec_step;
    logic [127:0] dec_key;
    logic [3:0]   dec_round;
    logic         key_ready;
    logic         expand_busy;
    logic         round_valid;
    logic [134:0] obs;

    int           checks   = 0;
    int           failures = 0;
    exp_t         sb[$];
    logic [127:0] rk [0:10];

    inv_round_key_gen dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .chg_key     (chg_key),
        .rx_key      (rx_key),
        .dec_start   (dec_start),
        .dec_step    (dec_step),
        .dec_key     (dec_key),
        .dec_round   (dec_round),
        .key_ready   (key_ready),
        .expand_busy (expand_busy),
        .round_valid (round_valid)
    );

    always #5 clk = ~clk;

    assign obs = {dec_key, dec_round, round_valid, key_ready, expand_busy};

    function automatic logic [134:0] pk(input logic [127:0] k, input logic [3:0] r,
                                        input logic v, input logic rdy, input logic busy);
        return {k, r, v, rdy, busy};
    endfunction

    task automatic compare(input string tag, input logic [134:0] o, input logic [134:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic expect_next(input string tag, input logic [134:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Advance one clock, release pulses, then retire one scoreboard entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chg_key   = 1'b0;
        dec_start = 1'b0;
        dec_step  = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            compare(e.tag, obs, e.v);
        end
    endtask

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        n_rst     = 1'b0;
        chg_key   = 1'b0;
        dec_start = 1'b0;
        dec_step  = 1'b0;
        rx_key    = '0;

        repeat (2) @(posedge clk);
        #1;
        compare("reset", obs, '0);
        n_rst = 1'b1;

        dec_start = 1'b1;
        expect_next("idle_start", '0);
        tick();
        dec_step = 1'b1;
        expect_next("idle_step", '0);
        tick();

        chg_key = 1'b1;
        rx_key  = C_KEY_A;
        expect_next("exp_sample", pk('0, 4'd0, 1'b0, 1'b0, 1'b1));
        tick();
        rx_key = '0;
        for (int i = 1; i <= 9; i++) begin
            if (i == 5) dec_start = 1'b1;
            expect_next("exp_busy", pk('0, 4'd0, 1'b0, 1'b0, 1'b1));
            tick();
        end
        expect_next("exp_ready", pk('0, 4'd0, 1'b0, 1'b1, 1'b0));
        tick();

        dec_start = 1'b1;
        expect_next("start_r10", pk(rk[10], 4'd10, 1'b1, 1'b1, 1'b0));
        tick();
        for (int r = 9; r >= 0; r--) begin
            dec_step = 1'b1;
            expect_next("step", pk(rk[r], 4'(r), 1'b1, 1'b1, 1'b0));
            tick();
        end
        dec_step = 1'b1;
        expect_next("step_at_0", pk(rk[0], 4'd0, 1'b1, 1'b1, 1'b0));
        tick();

        dec_start = 1'b1;
        expect_next("restart", pk(rk[10], 4'd10, 1'b1, 1'b1, 1'b0));
        tick();
        for (int r = 9; r >= 4; r--) begin
            dec_step = 1'b1;
            expect_next("step_to4", pk(rk[r], 4'(r), 1'b1, 1'b1, 1'b0));
            tick();
        end
        dec_start = 1'b1;
        dec_step  = 1'b1;
        expect_next("start_wins", pk(rk[10], 4'd10, 1'b1, 1'b1, 1'b0));
        tick();
        for (int r = 9; r >= 6; r--) begin
            dec_step = 1'b1;
            expect_next("step_to6", pk(rk[r], 4'(r), 1'b1, 1'b1, 1'b0));
            tick();
        end

        chg_key = 1'b1;
        rx_key  = C_KEY_B;
        expect_next("chg_mid_dec", pk(rk[6], 4'd6, 1'b0, 1'b0, 1'b1));
        tick();
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) dec_step = 1'b1;
            expect_next("b_busy", pk(rk[6], 4'd6, 1'b0, 1'b0, 1'b1));
            tick();
        end
        expect_next("b_ready", pk(rk[6], 4'd6, 1'b0, 1'b1, 1'b0));
        tick();
        dec_start = 1'b1;
        expect_next("b_start_r10", pk(C_B_R10, 4'd10, 1'b1, 1'b1, 1'b0));
        tick();

        chg_key = 1'b1;
        rx_key  = C_KEY_A;
        expect_next("c_sample", pk(C_B_R10, 4'd10, 1'b0, 1'b0, 1'b1));
        tick();
        expect_next("c_busy", pk(C_B_R10, 4'd10, 1'b0, 1'b0, 1'b1));
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        compare("async_reset", obs, '0);
        @(posedge clk);
        #1;
        compare("held_reset", obs, '0);
        n_rst = 1'b1;

        compare("sb_drained", 135'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
